// File: rtl/gate_test_sequencer.sv
// Sequencer that walks a logic gate DUT through its truth table and counts output mismatches.
// Optional build macro GATE_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_test_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      gate_sel,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] vec_idx
);

    // state    | meaning
    // IDLE     | waiting for start; results of the last run held
    // APPLY    | register the current vector onto dut_in
    // SETTLE   | hold dut_in for SETTLE cycles
    // CHECK    | compare dut_y with the golden value, advance or finish
    // DONE     | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [2:0]        gate_q, gate_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [N_IN-1:0]   vec_idx_q, vec_idx_d;
    logic [N_IN:0]     fail_cnt_q, fail_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              golden;
    logic              mismatch;
    logic              last_vec;
    logic [N_IN:0]     fail_inc;

    always_comb begin
        golden = 1'b0;
        case (gate_q)
            3'd0:    golden = ~dut_in_q[0];
            3'd1:    golden = &dut_in_q;
            3'd2:    golden = |dut_in_q;
            3'd3:    golden = ~(&dut_in_q);
            3'd4:    golden = ~(|dut_in_q);
            3'd5:    golden = ^dut_in_q;
            3'd6:    golden = ~(^dut_in_q);
            default: golden = 1'b0;
        endcase
    end

    // NOT only exercises dut_in[0], so its table ends after vector 1
    assign last_vec = (gate_q == 3'd0) ? (vec_idx_q == N_IN'(1)) : (&vec_idx_q);
    assign mismatch = (dut_y != golden);
    assign fail_inc = mismatch ? (fail_cnt_q + (N_IN+1)'(1)) : fail_cnt_q;

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        cnt_d      = cnt_q;
        dut_in_d   = dut_in_q;
        vec_idx_d  = vec_idx_q;
        fail_cnt_d = fail_cnt_q;
        busy_d     = busy_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gate_d     = gate_sel;
                    fail_cnt_d = '0;
                    vec_idx_d  = '0;
                    dut_in_d   = '0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (gate_q == 3'd7) begin
                    pass_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    dut_in_d = vec_idx_q;
                    cnt_d    = 4'(SETTLE - 1);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                fail_cnt_d = fail_inc;
                if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                    pass_d  = (fail_inc == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    vec_idx_d = vec_idx_q + N_IN'(1);
                    state_d   = ST_APPLY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gate_q     <= 3'd0;
            cnt_q      <= 4'd0;
            dut_in_q   <= '0;
            vec_idx_q  <= '0;
            fail_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            cnt_q      <= cnt_d;
            dut_in_q   <= dut_in_d;
            vec_idx_q  <= vec_idx_d;
            fail_cnt_q <= fail_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign dut_in   = dut_in_q;
    assign vec_idx  = vec_idx_q;
    assign fail_cnt = fail_cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer (N_IN=2, SETTLE=2) with a behavioural gate DUT model.
// Cycle 1 is the cycle right after the clock edge that accepts start.
module tb_gate_test_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] gate_sel;
    logic [1:0] dut_in;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_cnt;
    logic [1:0] vec_idx;

    int checks   = 0;
    int failures = 0;
    int dut_mode = 0;

    gate_test_sequencer #(.N_IN(2), .SETTLE(2)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .gate_sel (gate_sel),
        .dut_in   (dut_in),
        .dut_y    (dut_y),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_cnt (fail_cnt),
        .vec_idx  (vec_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: inverter on dut_in[0], mode 1: OR gate, mode 2: AND gate
    always_comb begin
        case (dut_mode)
            0:       dut_y = ~dut_in[0];
            1:       dut_y = |dut_in;
            default: dut_y = &dut_in;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] g);
        gate_sel = g;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // returns the cycle number on which done is seen, or -1 if the budget runs out
    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 2; i <= max_cyc; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        gate_sel = 3'd0;
        tick();
        tick();
        checks += 6;
        if (dut_in !== 2'd0)   begin failures++; $display("FAIL reset_dut_in got=%0d exp=0", dut_in); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (pass !== 1'b0)     begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
        if (fail_cnt !== 3'd0) begin failures++; $display("FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); end
        if (vec_idx !== 2'd0)  begin failures++; $display("FAIL reset_vec_idx got=%0d exp=0", vec_idx); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_not_gate();
        int cyc;
        dut_mode = 0;
        accept(3'd0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL not_busy got=%b exp=1", busy); end
        cyc = -1;
        for (int i = 2; i <= 30; i++) begin
            tick();
            if (i == 3) begin
                checks++;
                if (dut_in !== 2'd0) begin failures++; $display("FAIL not_vec0 got=%0d exp=0", dut_in); end
            end
            if (i == 7) begin
                checks++;
                if (dut_in !== 2'd1) begin failures++; $display("FAIL not_vec1 got=%0d exp=1", dut_in); end
            end
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        checks += 5;
        if (cyc != 9)          begin failures++; $display("FAIL not_done_cycle got=%0d exp=9", cyc); end
        if (pass !== 1'b1)     begin failures++; $display("FAIL not_pass got=%b exp=1", pass); end
        if (fail_cnt !== 3'd0) begin failures++; $display("FAIL not_fail_cnt got=%0d exp=0", fail_cnt); end
        if (vec_idx !== 2'd1)  begin failures++; $display("FAIL not_vec_idx got=%0d exp=1", vec_idx); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL not_busy_end got=%b exp=0", busy); end
        tick();
        checks += 2;
        if (done !== 1'b0) begin failures++; $display("FAIL not_done_width got=%b exp=0", done); end
        if (pass !== 1'b1) begin failures++; $display("FAIL not_pass_hold got=%b exp=1", pass); end
    endtask

    task automatic test_and_vs_or_dut();
        int cyc;
        int exp_cyc;
        logic [2:0] exp_fail;
        logic [1:0] exp_vec;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        exp_cyc = 9;  exp_fail = 3'd1; exp_vec = 2'd1;
`else
        exp_cyc = 17; exp_fail = 3'd2; exp_vec = 2'd3;
`endif
        dut_mode = 1;
        accept(3'd1);
        wait_done(60, cyc);
        checks += 5;
        if (cyc != exp_cyc)        begin failures++; $display("FAIL and_done_cycle got=%0d exp=%0d", cyc, exp_cyc); end
        if (fail_cnt !== exp_fail) begin failures++; $display("FAIL and_fail_cnt got=%0d exp=%0d", fail_cnt, exp_fail); end
        if (vec_idx !== exp_vec)   begin failures++; $display("FAIL and_vec_idx got=%0d exp=%0d", vec_idx, exp_vec); end
        if (dut_in !== exp_vec)    begin failures++; $display("FAIL and_dut_in got=%0d exp=%0d", dut_in, exp_vec); end
        if (pass !== 1'b0)         begin failures++; $display("FAIL and_pass got=%b exp=0", pass); end
        tick();
        tick();
        checks++;
        if (fail_cnt !== exp_fail) begin failures++; $display("FAIL and_fail_hold got=%0d exp=%0d", fail_cnt, exp_fail); end
    endtask

    task automatic test_invalid_gate();
        int cyc;
        accept(3'd7);
        checks++;
        if (dut_in !== 2'd0) begin failures++; $display("FAIL inv_dut_in_c1 got=%0d exp=0", dut_in); end
        wait_done(20, cyc);
        checks += 4;
        if (cyc != 2)          begin failures++; $display("FAIL inv_done_cycle got=%0d exp=2", cyc); end
        if (pass !== 1'b0)     begin failures++; $display("FAIL inv_pass got=%b exp=0", pass); end
        if (fail_cnt !== 3'd0) begin failures++; $display("FAIL inv_fail_cnt got=%0d exp=0", fail_cnt); end
        if (dut_in !== 2'd0)   begin failures++; $display("FAIL inv_dut_in got=%0d exp=0", dut_in); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int dones;
        dut_mode = 2;
        accept(3'd1);
        for (int i = 2; i <= 10; i++) tick();
        checks++;
        if (vec_idx !== 2'd2) begin failures++; $display("FAIL rst_pre_vec got=%0d exp=2", vec_idx); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (dut_in !== 2'd0)   begin failures++; $display("FAIL rst_dut_in got=%0d exp=0", dut_in); end
        if (vec_idx !== 2'd0)  begin failures++; $display("FAIL rst_vec_idx got=%0d exp=0", vec_idx); end
        if (fail_cnt !== 3'd0) begin failures++; $display("FAIL rst_fail_cnt got=%0d exp=0", fail_cnt); end
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL rst_no_activity got=%0d exp=0", dones); end
        accept(3'd1);
        wait_done(60, cyc);
        checks += 2;
        if (cyc != 17)     begin failures++; $display("FAIL rst_rerun_cycle got=%0d exp=17", cyc); end
        if (pass !== 1'b1) begin failures++; $display("FAIL rst_rerun_pass got=%b exp=1", pass); end
        tick();
    endtask

    task automatic test_start_held();
        int cyc;
        int dones;
        logic busy_c10;
        dut_mode = 0;
        gate_sel = 3'd0;
        start    = 1'b1;
        tick();
        dones    = 0;
        busy_c10 = 1'bx;
        for (int i = 2; i <= 10; i++) begin
            tick();
            if (done === 1'b1) dones++;
            if (i == 10) busy_c10 = busy;
        end
        tick();
        checks += 3;
        if (dones != 1)        begin failures++; $display("FAIL held_done_count got=%0d exp=1", dones); end
        if (busy_c10 !== 1'b0) begin failures++; $display("FAIL held_idle_gap got=%b exp=0", busy_c10); end
        if (busy !== 1'b1)     begin failures++; $display("FAIL held_second_start got=%b exp=1", busy); end
        start = 1'b0;
        wait_done(40, cyc);
        checks += 2;
        if (cyc != 9)      begin failures++; $display("FAIL held_second_done got=%0d exp=9", cyc); end
        if (pass !== 1'b1) begin failures++; $display("FAIL held_second_pass got=%b exp=1", pass); end
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        gate_sel = 3'd0;
        test_reset();
        test_not_gate();
        test_and_vs_or_dut();
        test_invalid_gate();
        test_reset_mid_run();
        test_start_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
